mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Multicycle MIPS control unit: drives the 3-bit F code and the datapath enables/selects around the 32-bit ALU, and consumes its Zero flag for branch resolution.
- Moore FSM sequences fetch/decode/execute per instruction. A combinational ALU decoder maps opcode/funct into the ALU function code.
- Sits between the instruction register and the multicycle datapath, with one memory port.

Parameters:
- MEM_WAIT_EN, 1: 1 = memory states stall on mem_ready; 0 = mem_ready ignored (single-cycle memory).

Ports:
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- op  input  6  instruction[31:26] from IR
- funct  input  6  instruction[5:0] from IR
- zero  input  1  ALU Zero flag
- mem_ready  input  1  memory access complete this cycle
- alu_control  output  3  ALU F: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- alu_src_a  output  1  0 = PC, 1 = reg A
- alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target
- ior_d  output  1  memory address: 0 = PC, 1 = ALUOut
- reg_dst, mem_to_reg  output  1 each  register-file write selects
- ir_write, pc_write, mem_write, reg_write, branch  output  1 each  enables
- pc_en  output  1  pc_write | (branch & zero)
- state  output  4  current state (debug)
- illegal_op  output  1  sticky illegal-opcode flag (optional feature)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Reset forces state = FETCH (0) and illegal_op = 0.
- While rst_n = 0: ir_write, pc_write, mem_write, reg_write, branch and pc_en are forced 0. All other outputs take FETCH values.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7
  - BEQ 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 12
- Transitions:
  - FETCH -> DECODE when (mem_ready | !MEM_WAIT_EN); otherwise hold.
  - DECODE on op: 100011 lw / 101011 sw -> MEMADR; 000000 -> EXEC; 000100 -> BEQ; 001000 -> ADDIEX; 000010 -> JUMP; other -> see Optional Feature.
  - MEMADR -> MEMRD (lw) or MEMWR (sw).
  - MEMRD -> MEMWB on ready, else hold. MEMWR -> FETCH on ready, else hold.
  - MEMWB, ALUWB, ADDIWB, BEQ, JUMP -> FETCH. EXEC -> ALUWB. ADDIEX -> ADDIWB.
  - Unused encodings 13-15 -> FETCH.
- Outputs per state (all unlisted outputs are 0):
  - FETCH: alu_src_b = 01, ADD. ir_write and pc_write = 1 only on the completing cycle (ready or !MEM_WAIT_EN).
  - DECODE: alu_src_b = 11, ADD.
  - MEMADR, ADDIEX: alu_src_a = 1, alu_src_b = 10, ADD.
  - MEMRD: ior_d = 1.
  - MEMWB: mem_to_reg = 1, reg_write = 1.
  - MEMWR: ior_d = 1, mem_write = 1 for every cycle in the state (held request).
  - EXEC: alu_src_a = 1, alu_src_b = 00, funct-decoded.
  - ALUWB: reg_dst = 1, reg_write = 1.
  - ADDIWB: reg_write = 1.
  - BEQ: alu_src_a = 1, SUB, pc_src = 01, branch = 1.
  - JUMP: pc_src = 10, pc_write = 1.
- Funct decode (EXEC only): 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Any other funct -> 010, with no error.
- pc_en is combinational, same cycle as zero. State register latency is 1 cycle.
- Instruction cycle counts with no stalls: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Optional Feature:
- Macro MIPS_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE -> ILLEGAL. ILLEGAL holds there with all enables 0 and sets illegal_op = 1; only rst_n exits.
- Undefined: an unknown op in DECODE -> FETCH (executes as a NOP, 2 cycles). illegal_op is tied 0.

Test Plan:
- Reset mid-EXEC: rst_n low -> state = 0 immediately (asynchronous), all enables 0. Release with mem_ready = 1 -> ir_write = 1 on the next edge, then state = 1.
- R-type op = 000000, funct = 101010, mem_ready = 1 -> states 0,1,6,7,0; alu_control = 111 in EXEC; reg_dst = 1, reg_write = 1 in ALUWB.
- lw op = 100011 with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles; reg_write = 1 only in MEMWB; ior_d = 1 throughout MEMRD.
- beq op = 000100: zero = 1 -> pc_en = 1 in BEQ, alu_control = 110. Repeat with zero = 0 -> pc_en = 0. Both return to FETCH.
- sw op = 101011, mem_ready low 2 cycles in MEMWR -> mem_write = 1 for 3 consecutive cycles, then FETCH. j op = 000010 -> pc_src = 10, pc_write = 1 for 1 cycle.
- op = 111111: with MIPS_CTRL_ILLEGAL_TRAP_EN -> state = 12 and illegal_op = 1 stuck across 10 cycles. Without it -> state returns to 0, illegal_op = 0.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with ALU decoder (optional trap: MIPS_CTRL_ILLEGAL_TRAP_EN)
module mips_multicycle_ctrl #(
    parameter logic MEM_WAIT_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_control,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       ior_d,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ir_write,
    output logic       pc_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       branch,
    output logic       pc_en,
    output logic [3:0] state,
    output logic       illegal_op
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;
    logic   mem_done;
    logic   ir_write_raw;
    logic   pc_write_raw;
    logic   mem_write_raw;
    logic   reg_write_raw;
    logic   branch_raw;
    logic [2:0] funct_alu;

    // A memory access completes on ready, or every cycle for single-cycle memory
    assign mem_done = mem_ready | ~MEM_WAIT_EN;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU decoder for R-type funct; unknown functs quietly fall back to ADD
    always_comb begin
        funct_alu = 3'b010;
        case (funct)
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b110;
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b101010: funct_alu = 3'b111;
            default:   funct_alu = 3'b010;
        endcase
    end

    // Next-state and Moore outputs per state
    always_comb begin
        state_d       = S_FETCH;
        alu_control   = 3'b000;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_src        = 2'b00;
        ior_d         = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        branch_raw    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b    = 2'b01;
                alu_control  = 3'b010;
                ir_write_raw = mem_done;
                pc_write_raw = mem_done;
                state_d      = mem_done ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b   = 2'b11;
                alu_control = 3'b010;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
                    default:      state_d = S_ILLEGAL;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
                state_d     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ior_d   = 1'b1;
                state_d = mem_done ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_MEMWR: begin
                ior_d         = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = mem_done ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a   = 1'b1;
                alu_control = funct_alu;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a   = 1'b1;
                alu_control = 3'b110;
                pc_src      = 2'b01;
                branch_raw  = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a   = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = 3'b010;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_raw = 1'b1;
            end
            S_JUMP: begin
                pc_src       = 2'b10;
                pc_write_raw = 1'b1;
            end
            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Enables are suppressed combinationally while reset is held
    assign ir_write  = ir_write_raw  & rst_n;
    assign pc_write  = pc_write_raw  & rst_n;
    assign mem_write = mem_write_raw & rst_n;
    assign reg_write = reg_write_raw & rst_n;
    assign branch    = branch_raw    & rst_n;
    assign pc_en     = pc_write | (branch & zero);
    assign state     = state_q;

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag raised on the same edge that enters the trap state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;
`else
    assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [2:0] alu_control;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       ior_d;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       ir_write;
    logic       pc_write;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic       pc_en;
    logic [3:0] state;
    logic       illegal_op;

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_q[$];
    string       tag_q[$];

    mips_multicycle_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_control(alu_control), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_src(pc_src), .ior_d(ior_d), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .ir_write(ir_write), .pc_write(pc_write),
        .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
        .pc_en(pc_en), .state(state), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Field order: state alu_control src_a src_b pc_src ior_d reg_dst mem_to_reg
    //              ir_write pc_write mem_write reg_write branch pc_en illegal_op
    function automatic logic [21:0] exp_vec(input logic [3:0] s, input logic [5:0] f,
                                            input logic rdy, input logic z,
                                            input logic rst_ok, input logic ill);
        logic [2:0] alu;
        logic a, ior, rd, m2r, irw, pcw, mw, rw, br;
        logic [1:0] b, ps;
        alu = 3'b000; a = 0; b = 2'b00; ps = 2'b00; ior = 0; rd = 0; m2r = 0;
        irw = 0; pcw = 0; mw = 0; rw = 0; br = 0;
        case (s)
            4'd0:  begin b = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
            4'd1:  begin b = 2'b11; alu = 3'b010; end
            4'd2, 4'd9: begin a = 1; b = 2'b10; alu = 3'b010; end
            4'd3:  ior = 1;
            4'd4:  begin m2r = 1; rw = 1; end
            4'd5:  begin ior = 1; mw = 1; end
            4'd6:  begin
                a = 1;
                case (f)
                    6'b100010: alu = 3'b110;
                    6'b100100: alu = 3'b000;
                    6'b100101: alu = 3'b001;
                    6'b101010: alu = 3'b111;
                    default:   alu = 3'b010;
                endcase
            end
            4'd7:  begin rd = 1; rw = 1; end
            4'd8:  begin a = 1; alu = 3'b110; ps = 2'b01; br = 1; end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        if (!rst_ok) begin
            irw = 0; pcw = 0; mw = 0; rw = 0; br = 0;
        end
        return {s, alu, a, b, ps, ior, rd, m2r, irw, pcw, mw, rw, br, pcw | (br & z), ill};
    endfunction

    // Drive one cycle of inputs, record the expected outputs for it, advance a clock
    task automatic step(input logic [3:0] s, input logic [5:0] o, input logic [5:0] f,
                        input logic rdy, input logic z, input logic ill, input string tag);
        op = o; funct = f; mem_ready = rdy; zero = z;
        exp_q.push_back(exp_vec(s, f, rdy, z, 1'b1, ill));
        tag_q.push_back(tag);
        @(posedge clk); #1;
    endtask

    task automatic push_reset(input string tag);
        exp_q.push_back(exp_vec(4'd0, funct, mem_ready, zero, 1'b0, 1'b0));
        tag_q.push_back(tag);
    endtask

    // Monitor: compare each queued expectation against the DUT mid-cycle
    initial begin
        logic [21:0] got, want;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                t = tag_q.pop_front();
                got = {state, alu_control, alu_src_a, alu_src_b, pc_src, ior_d, reg_dst,
                       mem_to_reg, ir_write, pc_write, mem_write, reg_write, branch,
                       pc_en, illegal_op};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL %s: got %b required %b (t=%0t)", t, got, want, $time);
                end
            end
        end
    end

    initial begin
        @(posedge clk); #1;
        push_reset("reset_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // R-type slt
        step(4'd0, 6'b000000, 6'b101010, 1, 0, 0, "rt_fetch");
        step(4'd1, 6'b000000, 6'b101010, 1, 0, 0, "rt_decode");
        step(4'd6, 6'b000000, 6'b101010, 1, 0, 0, "rt_exec_slt");
        step(4'd7, 6'b000000, 6'b101010, 1, 0, 0, "rt_aluwb");
        // R-type sub, then unknown funct falls back to add
        step(4'd0, 6'b000000, 6'b100010, 1, 0, 0, "sub_fetch");
        step(4'd1, 6'b000000, 6'b100010, 1, 0, 0, "sub_decode");
        step(4'd6, 6'b000000, 6'b100010, 1, 0, 0, "sub_exec");
        step(4'd7, 6'b000000, 6'b100010, 1, 0, 0, "sub_aluwb");
        step(4'd0, 6'b000000, 6'b111111, 1, 0, 0, "dflt_fetch");
        step(4'd1, 6'b000000, 6'b111111, 1, 0, 0, "dflt_decode");
        step(4'd6, 6'b000000, 6'b111111, 1, 0, 0, "dflt_exec_add");
        step(4'd7, 6'b000000, 6'b111111, 1, 0, 0, "dflt_aluwb");

        // lw with three stall cycles in MEMRD; FETCH also stalls once
        step(4'd0, 6'b100011, 6'd0, 0, 0, 0, "lw_fetch_stall");
        step(4'd0, 6'b100011, 6'd0, 1, 0, 0, "lw_fetch");
        step(4'd1, 6'b100011, 6'd0, 1, 0, 0, "lw_decode");
        step(4'd2, 6'b100011, 6'd0, 1, 0, 0, "lw_memadr");
        for (int i = 0; i < 3; i++) step(4'd3, 6'b100011, 6'd0, 0, 0, 0, "lw_memrd_stall");
        step(4'd3, 6'b100011, 6'd0, 1, 0, 0, "lw_memrd_done");
        step(4'd4, 6'b100011, 6'd0, 1, 0, 0, "lw_memwb");

        // beq taken and not taken
        step(4'd0, 6'b000100, 6'd0, 1, 0, 0, "beq1_fetch");
        step(4'd1, 6'b000100, 6'd0, 1, 0, 0, "beq1_decode");
        step(4'd8, 6'b000100, 6'd0, 1, 1, 0, "beq_taken");
        step(4'd0, 6'b000100, 6'd0, 1, 0, 0, "beq2_fetch");
        step(4'd1, 6'b000100, 6'd0, 1, 0, 0, "beq2_decode");
        step(4'd8, 6'b000100, 6'd0, 1, 0, 0, "beq_not_taken");

        // sw with two stall cycles in MEMWR
        step(4'd0, 6'b101011, 6'd0, 1, 0, 0, "sw_fetch");
        step(4'd1, 6'b101011, 6'd0, 1, 0, 0, "sw_decode");
        step(4'd2, 6'b101011, 6'd0, 1, 0, 0, "sw_memadr");
        step(4'd5, 6'b101011, 6'd0, 0, 0, 0, "sw_memwr_stall1");
        step(4'd5, 6'b101011, 6'd0, 0, 0, 0, "sw_memwr_stall2");
        step(4'd5, 6'b101011, 6'd0, 1, 0, 0, "sw_memwr_done");

        // j
        step(4'd0, 6'b000010, 6'd0, 1, 0, 0, "j_fetch");
        step(4'd1, 6'b000010, 6'd0, 1, 0, 0, "j_decode");
        step(4'd11, 6'b000010, 6'd0, 1, 0, 0, "j_jump");

        // addi
        step(4'd0, 6'b001000, 6'd0, 1, 0, 0, "addi_fetch");
        step(4'd1, 6'b001000, 6'd0, 1, 0, 0, "addi_decode");
        step(4'd9, 6'b001000, 6'd0, 1, 0, 0, "addi_ex");
        step(4'd10, 6'b001000, 6'd0, 1, 0, 0, "addi_wb");

        // Reset asserted mid-EXEC takes effect without a clock edge
        step(4'd0, 6'b000000, 6'b100000, 1, 0, 0, "rst_fetch");
        step(4'd1, 6'b000000, 6'b100000, 1, 0, 0, "rst_decode");
        #1;
        rst_n = 1'b0;
        push_reset("reset_mid_exec");
        @(posedge clk); #1;
        push_reset("reset_held");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(4'd0, 6'b000000, 6'b100000, 1, 0, 0, "post_reset_fetch");
        step(4'd1, 6'b000000, 6'b100000, 1, 0, 0, "post_reset_decode");
        step(4'd6, 6'b000000, 6'b100000, 1, 0, 0, "post_reset_exec");
        step(4'd7, 6'b000000, 6'b100000, 1, 0, 0, "post_reset_aluwb");

        // Unknown opcode
        step(4'd0, 6'b111111, 6'd0, 1, 0, 0, "ill_fetch");
        step(4'd1, 6'b111111, 6'd0, 1, 0, 0, "ill_decode");
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) step(4'd12, 6'b111111, 6'd0, 1, 0, 1, "ill_trap");
        #1;
        rst_n = 1'b0;
        push_reset("ill_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(4'd0, 6'b000000, 6'd0, 1, 0, 0, "ill_recover_fetch");
`else
        step(4'd0, 6'b111111, 6'd0, 1, 0, 0, "ill_nop_fetch");
        step(4'd1, 6'b111111, 6'd0, 1, 0, 0, "ill_nop_decode");
`endif

        // Let the monitor drain, bounded
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
